// File: rtl/sdram_ch_pkg.sv
// rtl/sdram_ch_pkg.sv - shared types for the SDRAM channel requester
package sdram_ch_pkg;

  localparam int ADDR_W = 27;
  localparam int DIN_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  typedef struct packed {
    logic              rnw;
    logic              b128;
    logic [ADDR_W-1:0] addr;
    logic [DIN_W-1:0]  din;
  } cmd_t;

endpackage

// File: rtl/sdram_cmd_fifo.sv
// rtl/sdram_cmd_fifo.sv - synchronous command FIFO, power-of-two depth
module sdram_cmd_fifo
  import sdram_ch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_ch1_requester.sv
// rtl/sdram_ch1_requester.sv - queued, one-outstanding request initiator for SDRAM channel 1
module sdram_ch1_requester
  import sdram_ch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic              cmd_128,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DIN_W-1:0]  cmd_din,
  output logic              rsp_valid,
  output logic [127:0]      rsp_data128,
  output logic [31:0]       rsp_data32,
  output logic              wr_done,
  output logic              timeout_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ch1_addr,
  output logic [DIN_W-1:0]  ch1_din,
  output logic              ch1_req,
  output logic              ch1_rnw,
  output logic              ch1_128,
  input  logic              ch1_ready,
  input  logic              ch1_reqprocessed,
  input  logic [127:0]      ch1_dout,
  input  logic [31:0]       ch1_dout32
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                 state;
  state_t                 state_next;
  cmd_t                   head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [$clog2(DEPTH):0] unused_count;
  logic                   unused_reqprocessed;
  logic                   rdy_q;
  logic                   rdy_rise;
  logic                   rsp_fire;
  logic                   wr_fire;
  logic                   to_fire;
  logic                   timer_clr;
  logic [TW-1:0]          timer;

  assign unused_reqprocessed = ch1_reqprocessed;
  assign rdy_rise  = ch1_ready & ~rdy_q;
  // A full FIFO still accepts when the head is leaving in the same cycle.
  assign cmd_ready = ~fifo_full | pop;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = ~fifo_empty | (state != IDLE);

  sdram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ('{rnw: cmd_rnw, b128: cmd_128, addr: cmd_addr, din: cmd_din}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rsp_fire   = 1'b0;
    wr_fire    = 1'b0;
    to_fire    = 1'b0;
    timer_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (rdy_rise) begin
          rsp_fire   = ch1_rnw;
          wr_fire    = ~ch1_rnw;
          state_next = GAP;
        end else if (timer == TW'(TIMEOUT)) begin
          to_fire    = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (!ch1_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ch1_req follows pop by one register, so it can only be high in ISSUE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_q       <= 1'b0;
      ch1_req     <= 1'b0;
      ch1_addr    <= '0;
      ch1_din     <= '0;
      ch1_rnw     <= 1'b0;
      ch1_128     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data128 <= '0;
      rsp_data32  <= '0;
      wr_done     <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
    end else begin
      rdy_q     <= ch1_ready;
      ch1_req   <= pop;
      rsp_valid <= rsp_fire;
      wr_done   <= wr_fire;
      if (pop) begin
        ch1_addr <= head.addr;
        ch1_din  <= head.din;
        ch1_rnw  <= head.rnw;
        ch1_128  <= head.b128;
      end
      if (rsp_fire) begin
        rsp_data128 <= ch1_dout;
        rsp_data32  <= ch1_dout32;
      end
      if (to_fire) timeout_err <= 1'b1;
      if (timer_clr)          timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
    end
  end

endmodule

// File: doc/sdram_ch1_requester.md
Name: sdram_ch1_requester

Overview:
- Client-side initiator for SDRAM channel 1. Runs in the clk_base (~33 MHz) domain next to the CPU/DMA side.
- Queues read/write commands in a small FIFO and issues them one at a time on the ch1 request interface.
- Single-cycle request pulses; completion tracked by rising edge of ch1_ready.
- Returns 128-bit or 32-bit read data to the client, flags controller timeouts.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 1023, clk cycles from request pulse to ch1_ready rising edge before abort

Ports:
- clk  in  1  clk_base-domain clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  FIFO not full
- cmd_rnw  in  1  1=read, 0=write
- cmd_128  in  1  1=128-bit read burst, 0=32-bit read
- cmd_addr  in  27  byte address; bit26 = chip select
- cmd_din  in  16  write data
- rsp_valid  out  1  one-cycle read-data strobe
- rsp_data128  out  128  burst data
- rsp_data32  out  32  single-word data
- wr_done  out  1  one-cycle write-complete strobe
- timeout_err  out  1  sticky, cleared by reset only
- busy  out  1  FIFO non-empty or transaction in flight
- ch1_addr  out  27  to controller
- ch1_din  out  16  to controller
- ch1_req  out  1  request pulse
- ch1_rnw  out  1  to controller
- ch1_128  out  1  to controller
- ch1_ready  in  1  completion (may be high 1–2 cycles)
- ch1_reqprocessed  in  1  controller accepted read
- ch1_dout  in  128  burst data
- ch1_dout32  in  32  word data, already byte-aligned

Behaviour:
- Reset values:
  - cmd_ready=1; rsp_valid=0; wr_done=0; timeout_err=0; busy=0; ch1_req=0.
  - ch1_addr, ch1_din, ch1_rnw, ch1_128, rsp_data* = 0.
  - FIFO emptied; state IDLE.
- FIFO:
  - Push when cmd_valid&cmd_ready; pop in IDLE when non-empty.
  - Simultaneous push+pop on a full FIFO is permitted; cmd_ready stays 1 in that cycle only if an entry is popped.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- ch1_ready edge: rdy_q registered each cycle; rdy_rise = ch1_ready & ~rdy_q.
- FSM:
  - IDLE: if FIFO non-empty, pop entry; drive ch1_addr/din/rnw/128 from it; ch1_req=1 → ISSUE.
  - ISSUE (1 cycle): ch1_req=0; clear timer → WAIT. ch1_req must never be high two consecutive cycles, because the controller samples the level as well as the edge.
  - WAIT:
    - Timer increments each cycle.
    - On rdy_rise: for a read, rsp_data128<=ch1_dout, rsp_data32<=ch1_dout32, rsp_valid=1; for a write, wr_done=1. → GAP.
    - If timer==TIMEOUT and no rdy_rise: timeout_err<=1; no rsp_valid/wr_done → GAP.
  - GAP (1 cycle): wait for ch1_ready to drop; if ch1_ready is still high, stay in GAP. → IDLE.
- ch1_addr/din/rnw/128 are held stable from IDLE exit until the next pop.
- ch1_reqprocessed is informational only; it does not change state.
- Latency:
  - Command to request: 1 cycle after push if the FIFO was empty and FSM is IDLE.
  - Minimum issue interval: 4 cycles (IDLE, ISSUE, WAIT≥1, GAP).
- busy = FIFO non-empty | state!=IDLE.
- A rdy_rise outside WAIT is ignored.
- Reset mid-transaction: returns to IDLE with no response. Whatever the controller later returns for that request is discarded because it arrives outside WAIT.

Decomposition:
- Package sdram_ch_pkg: state enum (IDLE, ISSUE, WAIT, GAP); command struct {rnw, b128, addr[26:0], din[15:0]}; ADDR_W=27.
- Sub-module sdram_cmd_fifo: synchronous FIFO of command structs, with push/pop/full/empty/count.

Test Plan:
- Read 32: push rnw=1, 128=0, addr=0x0000100; model raises ch1_ready 12 cycles after the pulse with ch1_dout32=0xDEADBEEF → exactly one ch1_req pulse; rsp_valid one cycle later; rsp_data32=0xDEADBEEF.
- Read 128: addr=0x4000000, ch1_dout=0x0123…CDEF → ch1_addr bit26=1; rsp_data128 matches; ch1_128=1 during the request.
- Write with a 2-cycle-wide ch1_ready: push 0x00000200/din=0xA5A5 → single wr_done; no second completion from the second ready cycle.
- Back-to-back: push 5 commands with DEPTH=4 → cmd_ready=0 after the 4th unpopped entry; all 5 issue in order; no two ch1_req high in consecutive cycles.
- Timeout: model never asserts ready, TIMEOUT=1023 → timeout_err=1 at cycle 1024 after the pulse; next queued command issues; no rsp_valid for the aborted one.
- Reset in WAIT: reset_n=0 for 1 cycle, then a late ch1_ready → no rsp_valid; busy=0; FIFO empty.
